// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU between two requesters.
// One operation in flight: operands are registered into the ALU, the result is registered
// out of it, and the owner's response is held until it is taken.
module alu_share_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 4
) (
  input  logic              clk,
  input  logic              resetn,
  // requester 0: integer pipeline EX stage
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp0_zero,
  // requester 1: multi-cycle / CP0 helper path
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp1_zero,
  // shared ALU
  output logic [OP_W-1:0]   alu_control,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_zero,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e              state_q;
  logic                owner_q;
  logic                rr_ptr_q;
  logic [OP_W-1:0]     op_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [DATA_W-1:0]   res_q;
  logic                zero_q;

  logic                grant;
  logic                accept;
  logic                rsp_done;

  // Grant selection: a lone requester always wins, contention falls back to rr_ptr.
  always_comb begin
    grant = rr_ptr_q;
    if (req0_valid && !req1_valid) begin
      grant = 1'b0;
    end else if (req1_valid && !req0_valid) begin
      grant = 1'b1;
    end
  end

  // Ready only in IDLE for the granted, valid requester; forced low while reset is asserted
  // so every output reads 0 during reset regardless of incoming requests.
  always_comb begin
    req0_ready = resetn && (state_q == StIdle) && req0_valid && (grant == 1'b0);
    req1_ready = resetn && (state_q == StIdle) && req1_valid && (grant == 1'b1);
    accept     = req0_ready || req1_ready;
    rsp_done   = (state_q == StResp) &&
                 (owner_q ? rsp1_ready : rsp0_ready);
  end

  // Response and ALU drive are decoded purely from registered state.
  always_comb begin
    rsp0_valid  = 1'b0;
    rsp0_result = '0;
    rsp0_zero   = 1'b0;
    rsp1_valid  = 1'b0;
    rsp1_result = '0;
    rsp1_zero   = 1'b0;
    if (state_q == StResp) begin
      if (owner_q) begin
        rsp1_valid  = 1'b1;
        rsp1_result = res_q;
        rsp1_zero   = zero_q;
      end else begin
        rsp0_valid  = 1'b1;
        rsp0_result = res_q;
        rsp0_zero   = zero_q;
      end
    end
    alu_control = op_q;
    alu_a       = a_q;
    alu_b       = b_q;
    busy        = (state_q == StExec) || (state_q == StResp);
  end

  // FSM with operand/result capture; rr_ptr moves only when a response completes.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      owner_q  <= 1'b0;
      rr_ptr_q <= 1'b0;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      zero_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            owner_q <= grant;
            op_q    <= grant ? req1_op : req0_op;
            a_q     <= grant ? req1_a  : req0_a;
            b_q     <= grant ? req1_b  : req0_b;
            state_q <= StExec;
          end
        end
        StExec: begin
          res_q   <= alu_result;
          zero_q  <= alu_zero;
          state_q <= StResp;
        end
        StResp: begin
          if (rsp_done) begin
            rr_ptr_q <= ~owner_q;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU attached to its ALU port.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [3:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp0_zero;
  logic        rsp1_valid, rsp1_ready, rsp1_zero;
  logic [31:0] rsp0_result, rsp1_result;
  logic [3:0]  alu_control;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_zero;
  logic        busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_W(32), .OP_W(4)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_op     (req0_op),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .rsp0_valid  (rsp0_valid),
    .rsp0_ready  (rsp0_ready),
    .rsp0_result (rsp0_result),
    .rsp0_zero   (rsp0_zero),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_op     (req1_op),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .rsp1_valid  (rsp1_valid),
    .rsp1_ready  (rsp1_ready),
    .rsp1_result (rsp1_result),
    .rsp1_zero   (rsp1_zero),
    .alu_control (alu_control),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .busy        (busy)
  );

  // Behavioural ALU: the environment the arbiter drives.
  always_comb begin
    alu_result = 32'd0;
    case (alu_control)
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0111: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      4'b1100: alu_result = ~(alu_a | alu_b);
      default: alu_result = 32'd0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #1;
    step();
    step();
    resetn = 1'b1;
    #1;
  endtask

  initial begin
    resetn     = 1'b0;
    req0_valid = 1'b0; req0_op = 4'd0; req0_a = 32'd0; req0_b = 32'd0;
    req1_valid = 1'b0; req1_op = 4'd0; req1_a = 32'd0; req1_b = 32'd0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #3;
    // Reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    check("rst_alu_control", 32'(alu_control), 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    step();
    resetn = 1'b1;
    #1;

    // 1: single add from requester 0
    req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 32'd5; req0_b = 32'd7;
    #1;
    check("t1_req0_ready", 32'(req0_ready), 32'd1);
    check("t1_req1_ready", 32'(req1_ready), 32'd0);
    step();
    req0_valid = 1'b0;
    #1;
    check("t1_exec_busy", 32'(busy), 32'd1);
    check("t1_exec_ready", 32'(req0_ready), 32'd0);
    check("t1_alu_control", 32'(alu_control), 32'h2);
    check("t1_alu_a", alu_a, 32'd5);
    check("t1_alu_b", alu_b, 32'd7);
    check("t1_exec_rsp0_valid", 32'(rsp0_valid), 32'd0);
    step();
    check("t1_rsp0_valid", 32'(rsp0_valid), 32'd1);
    check("t1_rsp0_result", rsp0_result, 32'd12);
    check("t1_rsp0_zero", 32'(rsp0_zero), 32'd0);
    check("t1_rsp1_valid", 32'(rsp1_valid), 32'd0);
    rsp0_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;
    check("t1_done_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("t1_done_busy", 32'(busy), 32'd0);

    // 2: both valid after reset, requester 0 first
    do_reset();
    req0_valid = 1'b1; req0_op = 4'b0110; req0_a = 32'd9;    req0_b = 32'd9;
    req1_valid = 1'b1; req1_op = 4'b0001; req1_a = 32'hF0;   req1_b = 32'h0F;
    #1;
    check("t2_req0_ready", 32'(req0_ready), 32'd1);
    check("t2_req1_ready", 32'(req1_ready), 32'd0);
    step();
    req0_valid = 1'b0;
    step();
    check("t2_rsp0_valid", 32'(rsp0_valid), 32'd1);
    check("t2_rsp0_result", rsp0_result, 32'd0);
    check("t2_rsp0_zero", 32'(rsp0_zero), 32'd1);
    check("t2_resp_req1_ready", 32'(req1_ready), 32'd0);
    rsp0_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;
    check("t2_req1_ready", 32'(req1_ready), 32'd1);
    step();
    req1_valid = 1'b0;
    step();
    check("t2_rsp1_valid", 32'(rsp1_valid), 32'd1);
    check("t2_rsp1_result", rsp1_result, 32'hFF);
    check("t2_rsp1_zero", 32'(rsp1_zero), 32'd0);
    check("t2_rsp0_idle", 32'(rsp0_valid), 32'd0);
    check("t2_rsp0_result_zeroed", rsp0_result, 32'd0);
    rsp1_ready = 1'b1;
    step();
    rsp1_ready = 1'b0;

    // 3: both held valid, four ops alternate 0,1,0,1 at one accept every three cycles
    do_reset();
    req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 32'd1;  req0_b = 32'd2;
    req1_valid = 1'b1; req1_op = 4'b0000; req1_a = 32'hFF; req1_b = 32'h3C;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check("t3_grant", {30'd0, req1_ready, req0_ready}, (i % 2 == 0) ? 32'd1 : 32'd2);
      step();
      check("t3_exec_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
      step();
      if (i % 2 == 0) begin
        check("t3_rsp0_result", rsp0_result, 32'd3);
        check("t3_rsp0_valid", 32'(rsp0_valid), 32'd1);
      end else begin
        check("t3_rsp1_result", rsp1_result, 32'h3C);
        check("t3_rsp1_valid", 32'(rsp1_valid), 32'd1);
      end
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #1;

    // 4: slt on requester 1 with a stalled response; requester 0 waits
    req1_valid = 1'b1; req1_op = 4'b0111; req1_a = 32'd3; req1_b = 32'd8;
    #1;
    check("t4_req1_ready", 32'(req1_ready), 32'd1);
    step();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 32'd4; req0_b = 32'd4;
    step();
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", 32'(rsp1_valid), 32'd1);
      check("t4_hold_result", rsp1_result, 32'd1);
      check("t4_hold_req0_ready", 32'(req0_ready), 32'd0);
      step();
    end
    rsp1_ready = 1'b1;
    #1;
    check("t4_ack_req0_ready", 32'(req0_ready), 32'd0);
    step();
    rsp1_ready = 1'b0;
    check("t4_req0_ready", 32'(req0_ready), 32'd1);
    check("t4_rsp1_dropped", 32'(rsp1_valid), 32'd0);
    step();
    req0_valid = 1'b0;
    step();
    check("t4_rsp0_result", rsp0_result, 32'd8);
    rsp0_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;

    // 5: reset during EXEC drops the op
    do_reset();
    req1_valid = 1'b1; req1_op = 4'b0010; req1_a = 32'd1; req1_b = 32'd1;
    step();
    req1_valid = 1'b0;
    step();
    rsp1_ready = 1'b1;
    step();
    rsp1_ready = 1'b0;
    // rr_ptr is now 0 after requester 1 completed; move it to 1 via a requester 0 op
    req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 32'd2; req0_b = 32'd2;
    step();
    req0_valid = 1'b0;
    step();
    rsp0_ready = 1'b1;
    step();
    rsp0_ready = 1'b0;
    req0_valid = 1'b1; req0_op = 4'b1100; req0_a = 32'd0; req0_b = 32'd0;
    step();
    req0_valid = 1'b0;
    #1;
    check("t5_exec_busy", 32'(busy), 32'd1);
    check("t5_exec_alu_control", 32'(alu_control), 32'hC);
    #2;
    resetn = 1'b0;
    #1;
    check("t5_rst_busy", 32'(busy), 32'd0);
    check("t5_rst_alu_control", 32'(alu_control), 32'd0);
    check("t5_rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("t5_rst_req0_ready", 32'(req0_ready), 32'd0);
    step();
    resetn = 1'b1;
    rsp0_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_no_rsp0", 32'(rsp0_valid), 32'd0);
    end
    rsp0_ready = 1'b0;
    // rr_ptr back at 0: contention goes to requester 0
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("t5_rr_ptr0", {30'd0, req1_ready, req0_ready}, 32'd1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;

    // 6: lone requester 1 with rr_ptr at 0 is granted every time
    rsp1_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req1_valid = 1'b1; req1_op = 4'b0001; req1_a = 32'(i); req1_b = 32'h100;
      #1;
      check("t6_req1_ready", 32'(req1_ready), 32'd1);
      step();
      req1_valid = 1'b0;
      step();
      check("t6_rsp1_result", rsp1_result, 32'h100 | 32'(i));
      step();
    end
    rsp1_ready = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
